nmi_sched: RTL and testbench

//  Collects NMI requests from several sources (slavespi, magic key, breakpoint, ...), applies a mask,

---
 rtl/nmi_sched.sv | 143 ++++++++++++++
 tb/tb_nmi_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nmi_sched.sv
// rtl/nmi_sched.sv - NMI request scheduler: mask, fixed-priority grant, set_nmi toggle, delivery tracking
//
// Collects one-cycle request strobes from NSRC sources, stores the enabled ones,
// grants the lowest pending index by toggling set_nmi, then follows the NMI
// generator through delivery (in_nmi rise) and service (in_nmi fall), followed by
// a one-frame holdoff, before the next grant is allowed.
//
// Ports:
//   fclk, rst_n   clock, asynchronous active-low reset
//   req           per-source request strobes (bit 0 = highest priority)
//   mask          per-source enable; masked strobes are dropped
//   int_start     start-of-INT strobe shared with the NMI generator
//   in_nmi        NMI-active level from the generator
//   set_nmi       toggle request to the generator
//   cause         index of the last granted source
//   cause_vld     cause not yet acknowledged
//   cause_ack     strobe clearing cause_vld
//   pend          stored, not-yet-granted requests
//   ovf           sticky overflow / lost-grant flag
//   ovf_clr       strobe clearing ovf
//   busy          scheduler is not idle
module nmi_sched #(
    parameter int NSRC    = 4,
    parameter int ARM_FRM = 2,
    localparam int CW     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            fclk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] req,
    input  logic [NSRC-1:0] mask,
    input  logic            int_start,
    input  logic            in_nmi,
    output logic            set_nmi,
    output logic [CW-1:0]   cause,
    output logic            cause_vld,
    input  logic            cause_ack,
    output logic [NSRC-1:0] pend,
    output logic            ovf,
    input  logic            ovf_clr,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_SERVE,
        S_GUARD
    } state_t;

    state_t          state;
    logic [3:0]      frm_cnt;

    logic [CW-1:0]   gnt_idx;
    logic            do_grant;
    logic [NSRC-1:0] gnt_mask;
    logic [NSRC-1:0] req_m;
    logic [NSRC-1:0] pend_left;
    logic            hit;
    logic [3:0]      frm_inc;
    logic            lost;

    always_comb begin
        gnt_idx = '0;
        // Descending scan so the lowest set index is the one that sticks.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                gnt_idx = CW'(i);
            end
        end
    end

    // No grant on an int_start cycle: the generator clears its own pending
    // request on that strobe, so a toggle there would be swallowed.
    assign do_grant  = (state == S_IDLE) && (|pend) && !in_nmi && !int_start;
    assign gnt_mask  = do_grant ? (NSRC'(1) << gnt_idx) : '0;
    assign req_m     = req & mask;
    assign pend_left = pend & ~gnt_mask;
    // A strobe on the bit being granted this cycle re-arms it without counting as overflow.
    assign hit       = |(req_m & pend_left);
    assign frm_inc   = frm_cnt + 4'd1;
    assign lost      = (state == S_ARMED) && !in_nmi && int_start && (frm_inc == 4'(ARM_FRM));

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            frm_cnt   <= 4'd0;
            set_nmi   <= 1'b0;
            cause     <= '0;
            cause_vld <= 1'b0;
            pend      <= '0;
            ovf       <= 1'b0;
        end else begin
            pend <= pend_left | req_m;
            ovf  <= hit | lost | (ovf & ~ovf_clr);

            if (do_grant) begin
                cause_vld <= 1'b1;
            end else if (cause_ack) begin
                cause_vld <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (do_grant) begin
                        cause   <= gnt_idx;
                        set_nmi <= ~set_nmi;
                        frm_cnt <= 4'd0;
                        state   <= S_ARMED;
                        busy    <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (in_nmi) begin
                        state <= S_SERVE;
                    end else if (int_start) begin
                        frm_cnt <= frm_inc;
                        if (lost) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_SERVE: begin
                    if (!in_nmi) begin
                        state <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (int_start) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nmi_sched.sv
// tb/tb_nmi_sched.sv - self-checking bench for nmi_sched: directed scenarios plus randomized traffic against a reference model
module tb_nmi_sched;

    localparam int NSRC    = 4;
    localparam int ARM_FRM = 2;

    localparam int PH_IDLE     = 0;
    localparam int PH_WAIT_DLV = 1;
    localparam int PH_IN_SVC   = 2;
    localparam int PH_HOLDOFF  = 3;

    logic            fclk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NSRC-1:0] req = '0;
    logic [NSRC-1:0] mask = '1;
    logic            int_start = 1'b0;
    logic            in_nmi = 1'b0;
    logic            set_nmi;
    logic [1:0]      cause;
    logic            cause_vld;
    logic            cause_ack = 1'b0;
    logic [NSRC-1:0] pend;
    logic            ovf;
    logic            ovf_clr = 1'b0;
    logic            busy;

    int checks = 0;
    int failures = 0;

    bit [NSRC-1:0] m_pend;
    bit            m_ovf;
    bit            m_set;
    bit            m_vld;
    int            m_cause;
    int            m_phase;
    int            m_frames;

    logic          prev_set;

    nmi_sched #(.NSRC(NSRC), .ARM_FRM(ARM_FRM)) dut (
        .fclk      (fclk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .int_start (int_start),
        .in_nmi    (in_nmi),
        .set_nmi   (set_nmi),
        .cause     (cause),
        .cause_vld (cause_vld),
        .cause_ack (cause_ack),
        .pend      (pend),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend   = '0;
        m_ovf    = 1'b0;
        m_set    = 1'b0;
        m_vld    = 1'b0;
        m_cause  = 0;
        m_phase  = PH_IDLE;
        m_frames = 0;
    endtask

    // One clock of the scheduler's rules, from the inputs seen at that edge.
    task automatic model_step(input bit [NSRC-1:0] r, input bit [NSRC-1:0] mk,
                              input bit ist, input bit inn, input bit ack, input bit clr);
        int g;
        bit hit;
        bit lost;
        g    = -1;
        hit  = 1'b0;
        lost = 1'b0;
        if (m_phase == PH_IDLE && !inn && !ist) begin
            for (int i = 0; i < NSRC; i++) begin
                if (m_pend[i] && g < 0) g = i;
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (r[i] && mk[i] && m_pend[i] && i != g) hit = 1'b1;
        end
        case (m_phase)
            PH_IDLE: begin
                if (g >= 0) begin
                    m_set    = !m_set;
                    m_cause  = g;
                    m_frames = 0;
                    m_phase  = PH_WAIT_DLV;
                end
            end
            PH_WAIT_DLV: begin
                if (inn) begin
                    m_phase = PH_IN_SVC;
                end else if (ist) begin
                    m_frames++;
                    if (m_frames == ARM_FRM) begin
                        lost    = 1'b1;
                        m_phase = PH_IDLE;
                    end
                end
            end
            PH_IN_SVC:  if (!inn) m_phase = PH_HOLDOFF;
            default:    if (ist) m_phase = PH_IDLE;
        endcase
        m_ovf = hit || lost || (m_ovf && !clr);
        if (g >= 0) m_vld = 1'b1;
        else if (ack) m_vld = 1'b0;
        if (g >= 0) m_pend[g] = 1'b0;
        m_pend = m_pend | (r & mk);
    endtask

    task automatic compare_all();
        check("set_nmi", 32'(set_nmi), 32'(m_set));
        check("cause", 32'(cause), 32'(m_cause));
        check("cause_vld", 32'(cause_vld), 32'(m_vld));
        check("pend", 32'(pend), 32'(m_pend));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("busy", 32'(busy), 32'(m_phase != PH_IDLE));
    endtask

    // Called at a falling edge: drive inputs, let the DUT clock, update model, compare.
    task automatic tick(input logic [NSRC-1:0] r, input logic [NSRC-1:0] mk, input logic ist,
                        input logic inn, input logic ack, input logic clr);
        req       = r;
        mask      = mk;
        int_start = ist;
        in_nmi    = inn;
        cause_ack = ack;
        ovf_clr   = clr;
        @(posedge fclk);
        model_step(r, mk, ist, inn, ack, clr);
        @(negedge fclk);
        compare_all();
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge fclk);
        compare_all();
        rst_n = 1'b1;
        @(negedge fclk);

        // 1: single request, toggle two clocks after the strobe
        prev_set = set_nmi;
        tick(4'b0100, 4'hF, 0, 0, 0, 0);
        check("t1_no_toggle_yet", 32'(set_nmi), 32'(prev_set));
        tick(4'b0000, 4'hF, 0, 0, 0, 0);
        check("t1_toggle", 32'(set_nmi), 32'(!prev_set));
        check("t1_cause", 32'(cause), 32'd2);
        check("t1_vld", 32'(cause_vld), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        tick(0, 4'hF, 0, 1, 1, 0);
        tick(0, 4'hF, 0, 0, 0, 0);
        tick(0, 4'hF, 1, 0, 0, 0);

        // 2: two simultaneous requests, priority order, holdoff before second grant
        tick(4'b1010, 4'hF, 0, 0, 0, 0);
        prev_set = set_nmi;
        tick(0, 4'hF, 0, 0, 0, 0);
        check("t2_cause_first", 32'(cause), 32'd1);
        check("t2_pend_left", 32'(pend), 32'h8);
        check("t2_toggle1", 32'(set_nmi), 32'(!prev_set));
        tick(0, 4'hF, 0, 1, 0, 0);
        tick(0, 4'hF, 0, 0, 0, 0);
        prev_set = set_nmi;
        tick(0, 4'hF, 0, 0, 0, 0);
        check("t2_guard_hold", 32'(set_nmi), 32'(prev_set));
        tick(0, 4'hF, 1, 0, 0, 0);
        tick(0, 4'hF, 0, 0, 0, 0);
        check("t2_toggle2", 32'(set_nmi), 32'(!prev_set));
        check("t2_cause_second", 32'(cause), 32'd3);
        tick(0, 4'hF, 0, 1, 1, 0);
        tick(0, 4'hF, 0, 0, 0, 0);
        tick(0, 4'hF, 1, 0, 0, 0);

        // 3: masked strobe dropped; repeated strobe on pending bit overflows
        tick(4'b0001, 4'b1110, 0, 0, 0, 0);
        check("t3_masked", 32'(pend), 32'h0);
        tick(4'b0001, 4'hF, 0, 1, 0, 0);
        tick(4'b0001, 4'hF, 0, 1, 0, 0);
        check("t3_ovf", 32'(ovf), 32'd1);
        tick(0, 4'hF, 0, 1, 0, 1);
        check("t3_ovf_clr", 32'(ovf), 32'd0);

        // 4: grant never delivered across ARM_FRM frames
        prev_set = set_nmi;
        tick(0, 4'hF, 0, 0, 0, 0);
        check("t4_toggle", 32'(set_nmi), 32'(!prev_set));
        tick(0, 4'hF, 1, 0, 0, 0);
        tick(0, 4'hF, 0, 0, 0, 0);
        tick(0, 4'hF, 1, 0, 0, 0);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_ovf", 32'(ovf), 32'd1);
        check("t4_no_extra", 32'(set_nmi), 32'(!prev_set));
        tick(0, 4'hF, 0, 0, 1, 1);

        // 5: grant blocked on an int_start cycle, delayed one clock
        tick(4'b0100, 4'hF, 0, 0, 0, 0);
        prev_set = set_nmi;
        tick(0, 4'hF, 1, 0, 0, 0);
        check("t5_blocked", 32'(set_nmi), 32'(prev_set));
        tick(0, 4'hF, 0, 0, 0, 0);
        check("t5_delayed", 32'(set_nmi), 32'(!prev_set));

        // 6: asynchronous reset while serving
        tick(4'b0010, 4'hF, 0, 1, 0, 0);
        tick(0, 4'hF, 0, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("t6_set_nmi", 32'(set_nmi), 32'd0);
        @(negedge fclk);
        rst_n = 1'b1;
        tick(0, 4'hF, 0, 1, 0, 0);
        tick(0, 4'hF, 0, 0, 0, 0);
        check("t6_no_toggle", 32'(set_nmi), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [NSRC-1:0] r;
            logic [NSRC-1:0] mk;
            logic            inn;
            r   = ($urandom_range(0, 5) == 0) ? NSRC'($urandom) : '0;
            mk  = ($urandom_range(0, 7) == 0) ? NSRC'($urandom) : '1;
            inn = ($urandom_range(0, 7) == 0) ? !in_nmi : in_nmi;
            tick(r, mk, $urandom_range(0, 9) == 0, inn,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
